// File: rtl/led_fader_pkg.sv
// Shared definitions for the multi-channel LED fader.
//   - MODE_* : encodings of the 2-bit mode input latched on start
//   - dir_e  : breathe direction (k counting down or up)
//   - state_e: sequencer state
package led_fader_pkg;

    localparam logic [1:0] MODE_FADE_OUT = 2'b00;
    localparam logic [1:0] MODE_FADE_IN  = 2'b01;
    localparam logic [1:0] MODE_BREATHE  = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic {
        DirDown = 1'b0,
        DirUp   = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRamp = 2'b01,
        StHold = 2'b10
    } state_e;

endpackage

// File: rtl/fade_scale.sv
// Combinational per-channel brightness scaler: scaled = floor(c * k / len).
// Ports:
//   c      in  CW  full-brightness channel value
//   k      in  DW  current phase, 0..len
//   len    in  DW  ramp length, never 0
//   scaled out CW  scaled channel value
module fade_scale #(
    parameter int unsigned CW = 8,
    parameter int unsigned DW = 16
) (
    input  logic [CW-1:0] c,
    input  logic [DW-1:0] k,
    input  logic [DW-1:0] len,
    output logic [CW-1:0] scaled
);

    logic [CW+DW-1:0] prod;

    assign prod = {{DW{1'b0}}, c} * {{CW{1'b0}}, k};

    // k <= len, so the quotient never exceeds c and fits in CW bits.
    assign scaled = CW'(prod / {{CW{1'b0}}, len});

endmodule

// File: rtl/led_fader_multi.sv
// Multi-channel LED fader: latches colour/duration/mode on start, then ramps
// the phase k under step_en and drives color_out = floor(C * k / L) per channel.
// Ports:
//   clock, reset       clock; asynchronous active-high reset
//   start, stop        single-cycle control pulses (start has priority)
//   step_en            phase advance strobe
//   mode, dur_in       sequence mode and length in steps (0 means 1)
//   color_in           NCH channels of CW bits, channel 0 in the LSBs
//   color_out          registered scaled colour, always matching current k
//   busy, done         sequence active; one-cycle completion pulse
module led_fader_multi
    import led_fader_pkg::*;
#(
    parameter int unsigned NCH = 3,
    parameter int unsigned CW  = 8,
    parameter int unsigned DW  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step_en,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     dur_in,
    input  logic [NCH*CW-1:0] color_in,
    output logic [NCH*CW-1:0] color_out,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d;
    logic [1:0]        mode_q, mode_d;
    logic [DW-1:0]     k_q, k_d;
    logic [DW-1:0]     len_q, len_d;
    logic [NCH*CW-1:0] c_q, c_d;
    logic              stop_pend_q, stop_pend_d;
    logic              busy_d, done_d;
    logic              finish;
    logic [DW-1:0]     dur_eff;
    logic [NCH*CW-1:0] scaled;

    assign dur_eff = (dur_in == '0) ? DW'(1) : dur_in;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        k_d         = k_q;
        len_d       = len_q;
        c_d         = c_q;
        stop_pend_d = stop_pend_q;
        busy_d      = busy;
        done_d      = 1'b0;
        finish      = 1'b0;

        if (start) begin
            c_d         = color_in;
            len_d       = dur_eff;
            mode_d      = mode;
            stop_pend_d = 1'b0;
            busy_d      = 1'b1;
            if (mode == MODE_FADE_IN) begin
                k_d   = '0;
                dir_d = DirUp;
            end else begin
                k_d   = dur_eff;
                dir_d = DirDown;
            end
            state_d = (mode == MODE_HOLD) ? StHold : StRamp;
        end else if (state_q != StIdle) begin
            if (stop) begin
                if (mode_q == MODE_BREATHE) begin
                    stop_pend_d = 1'b1;
                    dir_d       = DirDown;
                    if (k_q == '0) begin
                        // Stopped exactly at the bottom: nothing left to descend.
                        finish = 1'b1;
                    end else if (step_en) begin
                        k_d    = k_q - DW'(1);
                        finish = (k_q == DW'(1));
                    end
                end else begin
                    k_d    = '0;
                    finish = 1'b1;
                end
            end else if (step_en && state_q == StRamp) begin
                case (mode_q)
                    MODE_FADE_OUT: begin
                        k_d    = k_q - DW'(1);
                        finish = (k_q == DW'(1));
                    end
                    MODE_FADE_IN: begin
                        k_d    = k_q + DW'(1);
                        finish = (k_q + DW'(1) == len_q);
                    end
                    MODE_BREATHE: begin
                        if (dir_q == DirDown) begin
                            k_d = k_q - DW'(1);
                            if (k_q == DW'(1)) begin
                                if (stop_pend_q) finish = 1'b1;
                                else             dir_d  = DirUp;
                            end
                        end else begin
                            k_d = k_q + DW'(1);
                            if (k_q + DW'(1) == len_q) dir_d = DirDown;
                        end
                    end
                    default: ;
                endcase
            end

            if (finish) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
        end
    end

    // Scalers look at next-state values so color_out lands on the same edge as k.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fade_scale #(
            .CW(CW),
            .DW(DW)
        ) u_scale (
            .c     (c_d[i*CW +: CW]),
            .k     (k_d),
            .len   (len_d),
            .scaled(scaled[i*CW +: CW])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dir_q       <= DirDown;
            mode_q      <= MODE_FADE_OUT;
            k_q         <= '0;
            len_q       <= DW'(1);
            c_q         <= '0;
            stop_pend_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            color_out   <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            len_q       <= len_d;
            c_q         <= c_d;
            stop_pend_q <= stop_pend_d;
            busy        <= busy_d;
            done        <= done_d;
            color_out   <= scaled;
        end
    end

endmodule

// File: tb/tb_led_fader_multi.sv
module tb_led_fader_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop, step_en;
    logic [1:0]  mode;
    logic [15:0] dur_in;
    logic [23:0] color_in;
    logic [23:0] color_out;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;

    led_fader_multi #(
        .NCH(3),
        .CW (8),
        .DW (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .step_en  (step_en),
        .mode     (mode),
        .dur_in   (dur_in),
        .color_in (color_in),
        .color_out(color_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [23:0] col, input logic b,
                              input logic d);
        check_val({tag, " color"}, 32'(color_out), 32'(col));
        check_val({tag, " busy"}, 32'(busy), 32'(b));
        check_val({tag, " done"}, 32'(done), 32'(d));
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] d, input logic [23:0] c);
        start    = 1'b1;
        mode     = m;
        dur_in   = d;
        color_in = c;
        tick();
        start    = 1'b0;
        // Scramble sampled-only-at-start inputs to show they are ignored afterwards.
        mode     = ~m;
        dur_in   = 16'd7;
        color_in = 24'h5A5A5A;
    endtask

    logic [23:0] fo_seq [5] = '{24'hFF8040, 24'hBF6030, 24'h7F4020, 24'h3F2010, 24'h000000};
    logic [23:0] br_seq [8] = '{24'h80, 24'h40, 24'h00, 24'h40, 24'h80, 24'h40, 24'h00,
                                24'h40};

    initial begin
        reset = 1'b1; start = 0; stop = 0; step_en = 0;
        mode = 2'b00; dur_in = '0; color_in = '0;
        tick(); tick();
        expect_out("reset", 24'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("post reset idle", 24'h0, 1'b0, 1'b0);

        // Reset in the middle of a fade-out.
        step_en = 1'b1;
        do_start(2'b00, 16'd4, 24'hFF8040);
        tick();
        expect_out("pre-reset ramp", 24'hBF6030, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 expect_out("async reset", 24'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick(); tick();
        expect_out("idle after reset", 24'h0, 1'b0, 1'b0);

        // Fade-out, L=4, start with step_en high.
        do_start(2'b00, 16'd4, 24'hFF8040);
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("fade_out k%0d", 4 - i), fo_seq[i], i != 4, i == 4);
            if (i < 4) tick();
        end
        tick();
        expect_out("fade_out after", 24'h0, 1'b0, 1'b0);

        // Stop while idle does nothing.
        stop = 1'b1; tick(); stop = 1'b0;
        expect_out("idle stop", 24'h0, 1'b0, 1'b0);

        // Fade-in with dur 0 (treated as 1).
        do_start(2'b01, 16'd0, 24'h0000FF);
        expect_out("fade_in start", 24'h0, 1'b1, 1'b0);
        tick();
        expect_out("fade_in end", 24'h0000FF, 1'b0, 1'b1);
        tick();
        expect_out("fade_in hold", 24'h0000FF, 1'b0, 1'b0);

        // Breathe, L=2, then stop while rising.
        do_start(2'b10, 16'd2, 24'h000080);
        for (int i = 0; i < 8; i++) begin
            expect_out($sformatf("breathe %0d", i), br_seq[i], 1'b1, 1'b0);
            if (i < 7) tick();
        end
        step_en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("breathe stop", 24'h40, 1'b1, 1'b0);
        step_en = 1'b1;
        tick();
        expect_out("breathe end", 24'h0, 1'b0, 1'b1);
        tick();
        expect_out("breathe after", 24'h0, 1'b0, 1'b0);

        // Hold, step_en toggling, then stop.
        do_start(2'b11, 16'd5, 24'h123456);
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("hold %0d", i), 24'h123456, 1'b1, 1'b0);
            step_en = ~step_en;
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        expect_out("hold stop", 24'h0, 1'b0, 1'b1);
        tick();
        expect_out("hold after", 24'h0, 1'b0, 1'b0);

        // Retrigger a fade-out at k=2 with a fade-in.
        step_en = 1'b1;
        do_start(2'b00, 16'd4, 24'hFF8040);
        tick(); tick();
        expect_out("retrig pre", 24'h7F4020, 1'b1, 1'b0);
        do_start(2'b01, 16'd4, 24'h204080);
        expect_out("retrig start", 24'h0, 1'b1, 1'b0);
        tick();
        expect_out("retrig k1", 24'h081020, 1'b1, 1'b0);

        // Same-cycle start and stop: start wins.
        stop = 1'b1;
        do_start(2'b00, 16'd2, 24'h102030);
        stop = 1'b0;
        expect_out("start+stop", 24'h102030, 1'b1, 1'b0);
        tick();
        expect_out("start+stop k1", 24'h081018, 1'b1, 1'b0);
        tick();
        expect_out("start+stop end", 24'h0, 1'b0, 1'b1);

        // Fade-out abort by stop.
        do_start(2'b00, 16'd4, 24'hFF8040);
        stop = 1'b1; tick(); stop = 1'b0;
        expect_out("abort", 24'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
